// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared constants for the MicroCPU sequencer:
//   - opcode encodings (OP_*)
//   - sequencer FSM state type (seq_state_e)
//   - instruction field offsets: instr = {opcode, oper1[3:0], oper2[3:0], imm}
// ----------------------------------------------------------------------------
package core_pkg;

    // Opcode encodings. Anything not listed here executes as a NOP.
    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_JMP  = 1;
    localparam int unsigned OP_CALL = 2;
    localparam int unsigned OP_RET  = 3;
    localparam int unsigned OP_BREQ = 4;
    localparam int unsigned OP_BRNE = 5;
    localparam int unsigned OP_BRCS = 6;
    localparam int unsigned OP_BRCC = 7;
    localparam int unsigned OP_SAVE = 8;
    localparam int unsigned OP_LOAD = 9;
    localparam int unsigned OP_HLT  = 10;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWait,
        StHalt,
        StErr
    } seq_state_e;

    // Field offsets in the instruction word, as a function of the immediate width.
    function automatic int unsigned oper2_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned oper1_lsb(input int unsigned data_w);
        return data_w + 4;
    endfunction

    function automatic int unsigned opc_lsb(input int unsigned data_w);
        return data_w + 8;
    endfunction

endpackage

// File: rtl/core_ret_stack.sv
// ----------------------------------------------------------------------------
// core_ret_stack
// Return-address LIFO, ADDR_W bits x RSTK_DEPTH entries (depth power of 2, >=2).
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous, active-low reset (empties the stack)
//   push       in   write push_data on top (ignored when full)
//   pop        in   discard top entry (ignored when empty)
//   push_data  in   address to push
//   top_data   out  current top entry (meaningless when empty)
//   full       out  RSTK_DEPTH entries held
//   empty      out  no entries held
// ----------------------------------------------------------------------------
module core_ret_stack #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RSTK_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty
);

    // One extra pointer bit so that full and empty are distinguishable.
    localparam int unsigned PTR_W = $clog2(RSTK_DEPTH) + 1;

    logic [PTR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0] mem_q [RSTK_DEPTH];
    logic [PTR_W-2:0]  wr_idx;
    logic [PTR_W-2:0]  rd_idx;

    assign wr_idx   = ptr_q[PTR_W-2:0];
    assign rd_idx   = wr_idx - 1'b1;
    assign full     = (ptr_q == PTR_W'(RSTK_DEPTH));
    assign empty    = (ptr_q == '0);
    assign top_data = mem_q[rd_idx];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q <= '0;
            for (int i = 0; i < int'(RSTK_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[wr_idx] <= push_data;
            ptr_q         <= ptr_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - 1'b1;
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// ----------------------------------------------------------------------------
// core_seq_ctrl
// Multi-cycle fetch/decode/execute sequencer for the MicroCPU core, with
// fetch handshake, flag-conditional branches, CALL/RET return stack, store
// wait-states, HALT and sticky stack-error trap.
// Optional feature: define CORE_SEQ_INT_EN to enable vectored interrupts.
// Ports:
//   CLK, RESET            clock (rising edge), async active-low reset
//   fetch_req/fetch_ack   instruction fetch handshake at IP; instr valid on ack
//   instr                 {opcode, oper1[3:0], oper2[3:0], imm}
//   IP                    instruction pointer
//   exec_strobe           one-cycle pulse while the decoded instruction executes
//   exec_opcode/oper1/2   decoded fields, const_out = immediate
//   fl_zf, fl_cf          ALU flags, sampled in EXEC
//   store_req/store_busy  SAVE/LOAD start pulse / store unit busy
//   halted                core in HALT
//   stk_err               sticky return-stack overflow/underflow
//   int_req/int_num       interrupt request (level) and number
//   int_ack               one-cycle interrupt accept pulse
// ----------------------------------------------------------------------------
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned OPC_W        = 5,
    parameter int unsigned RSTK_DEPTH   = 8,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned INT_BASE     = 'h10
) (
    input  logic                    CLK,
    input  logic                    RESET,
    output logic                    fetch_req,
    input  logic                    fetch_ack,
    input  logic [OPC_W+8+DATA_W-1:0] instr,
    output logic [ADDR_W-1:0]       IP,
    output logic                    exec_strobe,
    output logic [OPC_W-1:0]        exec_opcode,
    output logic [3:0]              exec_oper1,
    output logic [3:0]              exec_oper2,
    output logic [DATA_W-1:0]       const_out,
    input  logic                    fl_zf,
    input  logic                    fl_cf,
    output logic                    store_req,
    input  logic                    store_busy,
    output logic                    halted,
    output logic                    stk_err,
    input  logic                    int_req,
    input  logic [3:0]              int_num,
    output logic                    int_ack
);

    localparam int unsigned INSTR_W = OPC_W + 8 + DATA_W;
    localparam int unsigned OPC_LSB = opc_lsb(DATA_W);
    localparam int unsigned OP1_LSB = oper1_lsb(DATA_W);
    localparam int unsigned OP2_LSB = oper2_lsb(DATA_W);

`ifdef CORE_SEQ_INT_EN
    // FETCH holds fetch_req low for one cycle so int_req can be sampled first.
    localparam bit REQ_ON_ENTRY = 1'b0;
`else
    // Raise fetch_req in the first FETCH cycle: 3 cycles per instruction.
    localparam bit REQ_ON_ENTRY = 1'b1;
`endif

    seq_state_e          state_q, state_d;
    logic                fetch_req_q, fetch_req_d;
    logic [ADDR_W-1:0]   ip_q, ip_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [3:0]          oper1_q, oper1_d;
    logic [3:0]          oper2_q, oper2_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                stk_err_q, stk_err_d;

    logic                stk_push;
    logic                stk_pop;
    logic [ADDR_W-1:0]   stk_wdata;
    logic [ADDR_W-1:0]   stk_top;
    logic                stk_full;
    logic                stk_empty;

    logic [ADDR_W-1:0]   ip_inc;
    logic [ADDR_W-1:0]   imm_addr;
    logic [ADDR_W-1:0]   int_vec;
    logic                int_take;

    assign ip_inc   = ip_q + 1'b1;
    assign imm_addr = ADDR_W'(imm_q);
    assign int_vec  = ADDR_W'(INT_BASE) + ADDR_W'(int_num);

`ifdef CORE_SEQ_INT_EN
    logic in_isr_q, in_isr_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            in_isr_q <= 1'b0;
        end else begin
            in_isr_q <= in_isr_d;
        end
    end
`else
    logic unused_int;
    assign unused_int = ^{int_req, int_num, int_vec};
`endif

    core_ret_stack #(
        .ADDR_W     (ADDR_W),
        .RSTK_DEPTH (RSTK_DEPTH)
    ) u_ret_stack (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (stk_wdata),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StFetch;
            fetch_req_q <= 1'b0;
            ip_q        <= ADDR_W'(RESET_VECTOR);
            instr_q     <= '0;
            opc_q       <= '0;
            oper1_q     <= '0;
            oper2_q     <= '0;
            imm_q       <= '0;
            stk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_req_q <= fetch_req_d;
            ip_q        <= ip_d;
            instr_q     <= instr_d;
            opc_q       <= opc_d;
            oper1_q     <= oper1_d;
            oper2_q     <= oper2_d;
            imm_q       <= imm_d;
            stk_err_q   <= stk_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_req_d = 1'b0;
        ip_d        = ip_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        oper1_d     = oper1_q;
        oper2_d     = oper2_q;
        imm_d       = imm_q;
        stk_err_d   = stk_err_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_wdata   = ip_inc;
        store_req   = 1'b0;
        exec_strobe = 1'b0;
        int_take    = 1'b0;
`ifdef CORE_SEQ_INT_EN
        in_isr_d    = in_isr_q;
`endif

        unique case (state_q)
            StFetch: begin
                if (fetch_req_q) begin
                    if (fetch_ack) begin
                        instr_d = instr;
                        state_d = StDecode;
                    end else begin
                        fetch_req_d = 1'b1;
                    end
                end else begin
`ifdef CORE_SEQ_INT_EN
                    if (int_req && !in_isr_q) begin
                        if (stk_full) begin
                            stk_err_d = 1'b1;
                            state_d   = StErr;
                        end else begin
                            // The not-yet-fetched instruction at IP is the return point.
                            stk_push    = 1'b1;
                            stk_wdata   = ip_q;
                            ip_d        = int_vec;
                            int_take    = 1'b1;
                            in_isr_d    = 1'b1;
                            fetch_req_d = 1'b1;
                        end
                    end else begin
                        fetch_req_d = 1'b1;
                    end
`else
                    fetch_req_d = 1'b1;
`endif
                end
            end

            StDecode: begin
                opc_d   = instr_q[OPC_LSB +: OPC_W];
                oper1_d = instr_q[OP1_LSB +: 4];
                oper2_d = instr_q[OP2_LSB +: 4];
                imm_d   = instr_q[DATA_W-1:0];
                state_d = StExec;
            end

            StExec: begin
                exec_strobe = 1'b1;
                ip_d        = ip_inc;
                state_d     = StFetch;
                fetch_req_d = REQ_ON_ENTRY;
                case (opc_q)
                    OPC_W'(OP_JMP):  ip_d = imm_addr;
                    OPC_W'(OP_BREQ): ip_d = fl_zf  ? imm_addr : ip_inc;
                    OPC_W'(OP_BRNE): ip_d = !fl_zf ? imm_addr : ip_inc;
                    OPC_W'(OP_BRCS): ip_d = fl_cf  ? imm_addr : ip_inc;
                    OPC_W'(OP_BRCC): ip_d = !fl_cf ? imm_addr : ip_inc;
                    OPC_W'(OP_CALL): begin
                        if (stk_full) begin
                            ip_d        = ip_q;
                            stk_err_d   = 1'b1;
                            state_d     = StErr;
                            fetch_req_d = 1'b0;
                        end else begin
                            stk_push = 1'b1;
                            ip_d     = imm_addr;
                        end
                    end
                    OPC_W'(OP_RET): begin
                        if (stk_empty) begin
                            ip_d        = ip_q;
                            stk_err_d   = 1'b1;
                            state_d     = StErr;
                            fetch_req_d = 1'b0;
                        end else begin
                            stk_pop = 1'b1;
                            ip_d    = stk_top;
`ifdef CORE_SEQ_INT_EN
                            in_isr_d = 1'b0;
`endif
                        end
                    end
                    OPC_W'(OP_SAVE), OPC_W'(OP_LOAD): begin
                        store_req   = 1'b1;
                        state_d     = StWait;
                        fetch_req_d = 1'b0;
                    end
                    OPC_W'(OP_HLT): begin
                        ip_d        = ip_q;
                        state_d     = StHalt;
                        fetch_req_d = 1'b0;
                    end
                    default: ip_d = ip_inc;
                endcase
            end

            StWait: begin
                if (!store_busy) begin
                    state_d     = StFetch;
                    fetch_req_d = REQ_ON_ENTRY;
                end
            end

            StHalt: begin
`ifdef CORE_SEQ_INT_EN
                if (int_req && !in_isr_q) begin
                    if (stk_full) begin
                        stk_err_d = 1'b1;
                        state_d   = StErr;
                    end else begin
                        // IP is frozen on the HLT, so return past it.
                        stk_push    = 1'b1;
                        stk_wdata   = ip_inc;
                        ip_d        = int_vec;
                        int_take    = 1'b1;
                        in_isr_d    = 1'b1;
                        state_d     = StFetch;
                        fetch_req_d = 1'b1;
                    end
                end
`endif
            end

            StErr: begin
                state_d = StErr;
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign fetch_req   = fetch_req_q;
    assign IP          = ip_q;
    assign exec_opcode = opc_q;
    assign exec_oper1  = oper1_q;
    assign exec_oper2  = oper2_q;
    assign const_out   = imm_q;
    assign halted      = (state_q == StHalt);
    assign stk_err     = stk_err_q;
    assign int_ack     = int_take;

endmodule
